// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and fixed constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: a bubble overrides a load; with neither it holds.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_p0,
  input  logic [ADDR_W-1:0]  pc_p0,
  input  logic [ADDR_W-1:0]  pc4_p0,
  output logic               vld_p1,
  output logic [INSTR_W-1:0] instr_p1,
  output logic [ADDR_W-1:0]  pc_p1,
  output logic [ADDR_W-1:0]  pc4_p1
);

  // IF -> ID boundary: bubble clears valid and the instruction, load captures a fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= INSTR_W'(NOP_INSTR);
      pc_p1    <= '0;
      pc4_p1   <= '0;
    end else if (bubble) begin
      vld_p1   <= 1'b0;
      instr_p1 <= INSTR_W'(NOP_INSTR);
    end else if (load) begin
      vld_p1   <= 1'b1;
      instr_p1 <= instr_p0;
      pc_p1    <= pc_p0;
      pc4_p1   <= pc4_p0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight,
// buffers a response that lands during a stall and squashes stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               ifid_valid_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [ADDR_W-1:0]  ifid_pc_o,
  output logic [ADDR_W-1:0]  ifid_pc4_o
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc4;
  logic [ADDR_W-1:0]  target_al;
  logic [INSTR_W-1:0] buf_q;
  logic               buf_we;
  logic               deliver;
  logic [INSTR_W-1:0] dlv_instr;
  logic               ifid_bubble;

  // Instructions are word aligned, so the low target bits are ignored.
  assign target_al = target_i & ~ADDR_W'(2'b11);
  assign pc4       = pc_q + ADDR_W'(PC_STEP);

  // The request strobe is suppressed while reset is held even though the FSM sits in ISSUE.
  assign imem_req_o  = rst_n_i && (state_q == ST_ISSUE);
  assign imem_addr_o = pc_q;

  // Next-state, next-PC and delivery decode; flush outranks stall everywhere
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_we    = 1'b0;
    deliver   = 1'b0;
    dlv_instr = imem_rdata_i;
    case (state_q)
      ST_ISSUE: begin
        if (flush_i) begin
          pc_d    = target_al;
          state_d = ST_DROP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (flush_i) begin
            pc_d    = target_al;
            state_d = ST_ISSUE;
          end else if (stall_i) begin
            buf_we  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            deliver = 1'b1;
            state_d = ST_ISSUE;
          end
        end else if (flush_i) begin
          pc_d    = target_al;
          state_d = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          pc_d    = target_al;
          state_d = ST_ISSUE;
        end else if (!stall_i) begin
          deliver   = 1'b1;
          dlv_instr = buf_q;
          state_d   = ST_ISSUE;
        end
      end
      ST_DROP: begin
        // A redirect here only retargets; the stale response is still owed.
        if (flush_i) pc_d = target_al;
        if (imem_rvalid_i) state_d = ST_ISSUE;
      end
      default: state_d = ST_ISSUE;
    endcase
    if (deliver) pc_d = pc4;
  end

  // FSM state and PC registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_ISSUE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Holding buffer for a response that arrived while decode was stalled
  always_ff @(posedge clk_i) begin
    if (buf_we) buf_q <= imem_rdata_i;
  end

  // Anything other than a delivery or a stall leaves a bubble in decode.
  assign ifid_bubble = flush_i || (!stall_i && !deliver);

  // IF -> ID boundary
  ifid_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .load     (deliver),
    .bubble   (ifid_bubble),
    .instr_p0 (dlv_instr),
    .pc_p0    (pc_q),
    .pc4_p0   (pc4),
    .vld_p1   (ifid_valid_o),
    .instr_p1 (ifid_instr_o),
    .pc_p1    (ifid_pc_o),
    .pc4_p1   (ifid_pc4_o)
  );

endmodule
